norm_sqrt_unit: RTL
===================

Name: norm_sqrt_unit

Overview:
- Final stage of the vector norm processor. It sits directly downstream of the controller/ALU accumulator.
- When the controller finishes walking the vector list, the accumulated sum of squares is handed to this block.
- The block computes the integer norm, floor(sqrt(sum)), and the remainder, using an iterative digit-by-digit method at one result bit per clock.
- Results are held stable for the result register and the host until the next request is accepted.

Parameters:
- word_size, 24: radicand width. Must be even.
- root_bits, word_size/2: derived localparam, not overridable. Sets the root width.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request pulse. Sampled on each rising clk edge.
- radicand, input, word_size: sum of squares from the accumulator. Captured on the edge where start is accepted.
- busy, output, 1: high while iterations are in progress.
- done, output, 1: one-cycle pulse marking root/rem valid.
- root, output, root_bits: floor(sqrt(radicand)).
- rem, output, root_bits+1: radicand - root*root. Maximum value is 2*root, so it fits.

Behaviour:
- Reset: rst high at a clk edge forces state to IDLE and clears all outputs and internal registers: busy=0, done=0, root=0, rem=0. Reset wins over start on the same edge. Reset mid-CALC aborts the operation and no done is issued.
- States: IDLE, CALC, DONE. Encoding: IDLE=0, CALC=1, DONE=2. Code 3 goes to IDLE.
- IDLE:
  - If start=1, load shift register sr=radicand, clear the partial root q=0 and remainder r=0, set counter cnt=root_bits, then go to CALC.
  - Otherwise stay in IDLE.
  - root/rem keep their last values.
- CALC:
  - busy=1. Each edge performs one iteration:
    - r' = (r<<2) | sr[top two bits]; sr <<= 2
    - t = (q<<2) | 1
    - if r' >= t then r = r' - t and q = (q<<1)|1, else r = r' and q = q<<1
  - cnt decrements by 1 per iteration. After the iteration where cnt reaches 0, go to DONE.
  - Width rule: r is computed internally at root_bits+2 bits, and the compare is unsigned.
  - start is ignored while in CALC.
- DONE:
  - done=1 and busy=0 for exactly one cycle. root=q and rem=r[root_bits:0] are registered on entry.
  - If start=1 in DONE, it is accepted exactly as in IDLE, with next state CALC; this supports back-to-back requests.
  - Otherwise go to IDLE.
- Outputs:
  - root/rem change only on entry to DONE.
  - They hold stable through IDLE and CALC until the next DONE (or reset).
- Latency:
  - start accepted at edge E0. busy is high for cycles E0..E(root_bits).
  - done is high for the cycle following edge E(root_bits), i.e. 13 cycles after acceptance at the default size.
  - Throughput is one result per root_bits+1 cycles.
- Boundaries:
  - radicand=0 gives root=0, rem=0.
  - radicand at its maximum gives root at its maximum and rem=2*root, with no overflow.
  - A start held high continuously restarts on every DONE cycle.
  - radicand changes after acceptance have no effect.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 → busy=0, done=0, root=0, rem=0, and no done pulse is ever issued.
- Perfect square: radicand=25 (a 3-4 vector), start pulse → done exactly 13 cycles after the start edge, root=5, rem=0; done=1 for one cycle only.
- Non-square and zero: radicand=145 → root=12, rem=1; then radicand=0 → root=0, rem=0.
- Full scale: radicand=24'hFFFFFF → root=4095, rem=8190.
- Ignore and back-to-back:
  - Pulse start again mid-CALC with radicand=9 → ignored; the result is for the original operand (144 → root=12, rem=0).
  - Assert start with radicand=9 in the DONE cycle → second done 13 cycles later with root=3, rem=0.
- Reset mid-operation: start with radicand=1000, assert rst on the 5th CALC cycle → state IDLE, busy=0, root=0, rem=0, and no done follows. A subsequent start with 1000 → root=31, rem=39.

Source files
------------

// File: rtl/norm_sqrt_unit.sv
// Integer square root of the accumulated sum of squares, one root bit per clock.
// Produces floor(sqrt(radicand)) and the remainder radicand - root*root.
module norm_sqrt_unit #(
  parameter int unsigned word_size = 24,
  localparam int unsigned root_bits = word_size / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [word_size-1:0] radicand,
  output logic                 busy,
  output logic                 done,
  output logic [root_bits-1:0] root,
  output logic [root_bits:0]   rem
);

  localparam int unsigned RW   = root_bits + 2;
  localparam int unsigned CntW = $clog2(root_bits + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [word_size-1:0] sr_q, sr_d;
  logic [root_bits-1:0] q_q, q_d;
  logic [RW-1:0]        r_q, r_d;
  logic [RW-1:0]        r_shift, trial;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ge;

  // One digit-by-digit iteration: bring down two radicand bits, try appending a 1.
  always_comb begin
    r_shift = (r_q << 2) | RW'(sr_q[word_size-1 -: 2]);
    trial   = {q_q, 2'b01};
    ge      = (r_shift >= trial);
    sr_d    = sr_q << 2;
    q_d     = (q_q << 1) | root_bits'(ge);
    r_d     = ge ? (r_shift - trial) : r_shift;
    cnt_d   = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      root    <= '0;
      rem     <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        // DONE accepts a new request just like IDLE so requests can run back to back.
        IDLE, DONE: begin
          if (start) begin
            sr_q    <= radicand;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= CntW'(root_bits);
            busy    <= 1'b1;
            state_q <= CALC;
          end else begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          sr_q  <= sr_d;
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            root    <= q_d;
            rem     <= r_d[root_bits:0];
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
